// File: rtl/crossbar_pkg.sv
// Shared widths, source indices and FSM states for the 4x4 crossbar route controller.
package crossbar_pkg;

    localparam int unsigned CTRL_W    = 5;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned NUM_PORTS = 4;

    localparam logic [SEL_W-1:0] IDX_IN1 = 2'd0;
    localparam logic [SEL_W-1:0] IDX_IN2 = 2'd1;
    localparam logic [SEL_W-1:0] IDX_IN3 = 2'd2;
    localparam logic [SEL_W-1:0] IDX_IN4 = 2'd3;

    localparam logic [CTRL_W-1:0] CAND_MAX = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SEARCH,
        DONE
    } state_t;

endpackage

// File: rtl/crossbar_4x4_route_model.sv
// Index-level model of the five-switch crossbar: for a control word, which input feeds each output.
module crossbar_4x4_route_model
    import crossbar_pkg::*;
(
    input  logic [CTRL_W-1:0] control,
    output logic [SEL_W-1:0]  src_out1,
    output logic [SEL_W-1:0]  src_out2,
    output logic [SEL_W-1:0]  src_out3,
    output logic [SEL_W-1:0]  src_out4
);

    logic [SEL_W-1:0] w_c0_o1, w_c0_o2;
    logic [SEL_W-1:0] w_c3_o1, w_c3_o2;
    logic [SEL_W-1:0] w_c2_o1, w_c2_o2;

    // Each switch: bit clear passes a->out1/b->out2, bit set crosses them.
    assign w_c0_o1 = control[0] ? IDX_IN2 : IDX_IN1;
    assign w_c0_o2 = control[0] ? IDX_IN1 : IDX_IN2;
    assign w_c3_o1 = control[3] ? IDX_IN4 : IDX_IN3;
    assign w_c3_o2 = control[3] ? IDX_IN3 : IDX_IN4;

    assign w_c2_o1 = control[2] ? w_c3_o1 : w_c0_o2;
    assign w_c2_o2 = control[2] ? w_c0_o2 : w_c3_o1;

    assign src_out1 = control[1] ? w_c2_o1 : w_c0_o1;
    assign src_out2 = control[1] ? w_c0_o1 : w_c2_o1;
    assign src_out3 = control[4] ? w_c3_o2 : w_c2_o2;
    assign src_out4 = control[4] ? w_c2_o2 : w_c3_o2;

endmodule

// File: rtl/crossbar_4x4_route_ctrl.sv
// Finds the lowest 5-bit control word realising a requested permutation and applies it to the crossbar.
module crossbar_4x4_route_ctrl
    import crossbar_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NUM_PORTS*SEL_W-1:0]  req_perm,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_err,
    output logic [CTRL_W-1:0]           rsp_ctrl,
    output logic [CTRL_W-1:0]           xbar_control
);

    state_t                       r_state;
    logic [NUM_PORTS*SEL_W-1:0]   r_perm;
    logic [CTRL_W-1:0]            r_cand;
    logic                         r_req_ready;
    logic                         r_rsp_valid;
    logic                         r_rsp_err;
    logic [CTRL_W-1:0]            r_rsp_ctrl;
    logic [CTRL_W-1:0]            r_xbar_control;

    logic [SEL_W-1:0] w_src1, w_src2, w_src3, w_src4;
    logic             w_dup;
    logic             w_match;

    crossbar_4x4_route_model u_model (
        .control  (r_cand),
        .src_out1 (w_src1),
        .src_out2 (w_src2),
        .src_out3 (w_src3),
        .src_out4 (w_src4)
    );

    always_comb begin
        w_dup = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            for (int unsigned j = i + 1; j < NUM_PORTS; j++) begin
                if (r_perm[i*SEL_W +: SEL_W] == r_perm[j*SEL_W +: SEL_W]) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    assign w_match = ({w_src4, w_src3, w_src2, w_src1} == r_perm);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_perm         <= '0;
            r_cand         <= '0;
            r_req_ready    <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_ctrl     <= '0;
            r_xbar_control <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_perm      <= req_perm;
                        r_req_ready <= 1'b0;
                        r_state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_dup) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_ctrl  <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_cand  <= '0;
                        r_state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (w_match) begin
                        r_rsp_valid    <= 1'b1;
                        r_rsp_err      <= 1'b0;
                        r_rsp_ctrl     <= r_cand;
                        r_xbar_control <= r_cand;
                        r_state        <= DONE;
                    end else if (r_cand == CAND_MAX) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_ctrl  <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_cand <= r_cand + CTRL_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_ctrl     = r_rsp_ctrl;
    assign xbar_control = r_xbar_control;

endmodule

// File: tb/tb_crossbar_4x4_route_ctrl.sv
// Self-checking bench for crossbar_4x4_route_ctrl against a swap-table permutation model.
module tb_crossbar_4x4_route_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_perm;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_err;
    logic [4:0] rsp_ctrl;
    logic [4:0] xbar_control;
    logic [1:0] g_src1, g_src2, g_src3, g_src4;

    int n_cmp;
    int n_err;
    logic [4:0] exp_xbar;
    int n_routable;

    crossbar_4x4_route_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_perm     (req_perm),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_err      (rsp_err),
        .rsp_ctrl     (rsp_ctrl),
        .xbar_control (xbar_control)
    );

    crossbar_4x4_route_model golden (
        .control  (rsp_ctrl),
        .src_out1 (g_src1),
        .src_out2 (g_src2),
        .src_out3 (g_src3),
        .src_out4 (g_src4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Wire positions 0..3 carry a label; each switch optionally swaps two adjacent positions.
    function automatic logic [7:0] ref_route(input logic [4:0] c);
        int unsigned pos[4] = '{0, 1, 2, 3};
        int unsigned sw_bit[5] = '{0, 3, 2, 1, 4};
        int unsigned sw_lo[5]  = '{0, 2, 1, 0, 2};
        int unsigned t;
        for (int s = 0; s < 5; s++) begin
            if (c[sw_bit[s]]) begin
                t = pos[sw_lo[s]];
                pos[sw_lo[s]] = pos[sw_lo[s] + 1];
                pos[sw_lo[s] + 1] = t;
            end
        end
        return {2'(pos[3]), 2'(pos[2]), 2'(pos[1]), 2'(pos[0])};
    endfunction

    task automatic ref_expect(input logic [7:0] p, output logic err, output logic [4:0] ctrl,
                              output int lat);
        logic dup;
        logic [7:0] pp;
        pp = p;
        dup = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (pp[2*i +: 2] == pp[2*j +: 2]) dup = 1'b1;
        err = 1'b1;
        ctrl = '0;
        lat = 34;
        if (dup) begin
            lat = 2;
        end else begin
            for (int c = 31; c >= 0; c--) begin
                if (ref_route(5'(c)) == p) begin
                    err = 1'b0;
                    ctrl = 5'(c);
                    lat = 3 + c;
                end
            end
        end
    endtask

    task automatic run_req(input logic [7:0] p, input int hold);
        logic       e_err;
        logic [4:0] e_ctrl;
        int         e_lat;
        int         k;
        logic       busy_ok;
        ref_expect(p, e_err, e_ctrl, e_lat);
        @(negedge clk);
        check_eq("ready_idle", req_ready, 1'b1);
        req_perm  = p;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_perm  = 8'($urandom);
        k = 0;
        busy_ok = 1'b1;
        while (!rsp_valid && k < 40) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            k++;
        end
        // Cycle T+n begins at edge T+n-1, so the response shows up n-1 edges after acceptance.
        check_eq("latency", k, e_lat - 1);
        check_eq("ready_busy", busy_ok, 1'b1);
        check_eq("rsp_err", rsp_err, e_err);
        check_eq("rsp_ctrl", rsp_ctrl, e_ctrl);
        if (!e_err) begin
            exp_xbar = e_ctrl;
            check_eq("golden_route", {g_src4, g_src3, g_src2, g_src1}, p);
        end
        check_eq("xbar_control", xbar_control, exp_xbar);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", rsp_valid, 1'b1);
            check_eq("hold_err", rsp_err, e_err);
            check_eq("hold_ctrl", rsp_ctrl, e_ctrl);
            check_eq("hold_ready", req_ready, 1'b0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("valid_drop", rsp_valid, 1'b0);
        check_eq("ready_back", req_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] p;
        logic       e_err;
        logic [4:0] e_ctrl;
        int         e_lat;
        n_cmp = 0;
        n_err = 0;
        n_routable = 0;
        exp_xbar = '0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_perm = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", req_ready, 1'b1);
        check_eq("rst_valid", rsp_valid, 1'b0);
        check_eq("rst_err", rsp_err, 1'b0);
        check_eq("rst_ctrl", rsp_ctrl, 5'd0);
        check_eq("rst_xbar", xbar_control, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        run_req(8'b11_10_01_00, 0);
        run_req(8'b11_10_00_01, 0);
        check_eq("xbar_after_swap", xbar_control, 5'd1);
        run_req(8'b00_01_10_11, 10);
        check_eq("xbar_kept", xbar_control, 5'd1);
        run_req(8'b11_10_00_00, 0);

        // Abandon an unroutable search partway through with a reset.
        @(negedge clk);
        req_perm  = 8'b00_01_10_11;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_xbar = '0;
        check_eq("midrst_ready", req_ready, 1'b1);
        check_eq("midrst_valid", rsp_valid, 1'b0);
        check_eq("midrst_xbar", xbar_control, 5'd0);
        check_eq("midrst_err", rsp_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++)
                    for (int d = 0; d < 4; d++)
                        if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                            p = {2'(d), 2'(c), 2'(b), 2'(a)};
                            ref_expect(p, e_err, e_ctrl, e_lat);
                            if (!e_err) n_routable++;
                            check_eq("unroutable_rule", e_err, (a >= 2 && b >= 2) ? 1'b1 : 1'b0);
                            run_req(p, $urandom_range(0, 3));
                        end
        check_eq("routable_count", n_routable, 20);

        for (int r = 0; r < 30; r++) begin
            run_req(8'($urandom), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crossbar_4x4_route_ctrl.md
Name: crossbar_4x4_route_ctrl

Overview:
Configuration-side counterpart of the 4x4 4-bit crossbar. The crossbar is five 2x2 switches:
- C0 on (in1,in2); C3 on (in3,in4); C2 on (C0.out2, C3.out1).
- C1 on (C0.out1, C2.out1) drives out1/out2; C4 on (C2.out2, C3.out2) drives out3/out4.
- control[k] drives Ck: 0 = pass, 1 = cross.

The block accepts a requested permutation (source input per output) and searches for a 5-bit control word that realises it. It reports either the word or an error. On success it holds that word on a registered port that drives the crossbar's control input.

Parameters:
CTRL_W, 5, control word width (fixed by switch count; not to be overridden)
SEL_W, 2, width of one source index (0=in1 .. 3=in4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  permutation request valid
req_ready  out  1  block can accept a request
req_perm  in  8  [1:0]=source of out1, [3:2]=out2, [5:4]=out3, [7:6]=out4
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_err  out  1  1 = request not a permutation or not routable
rsp_ctrl  out  5  control found (0 when rsp_err=1)
xbar_control  out  5  control word applied to crossbar; updates only on success

Behaviour:
- Single clock clk; synchronous active-high rst. All state changes on the rising edge of clk.
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_ctrl=0, xbar_control=0 (identity), cand=0. rst overrides everything, including mid-search and pending-response states; a pending result is dropped.
- FSM states IDLE, CHECK, SEARCH, DONE.
- IDLE:
  - req_ready=1; all other states req_ready=0.
  - On req_valid&&req_ready: latch req_perm and go to CHECK.
- CHECK (1 cycle):
  - If any two 2-bit fields of the latched permutation are equal: go to DONE with err=1, ctrl=0.
  - Otherwise go to SEARCH with cand=0.
- SEARCH (one candidate per cycle, ascending 0..31):
  - The route model maps cand to the source index of each output.
  - On match: DONE with err=0, ctrl=cand, and xbar_control<=cand in the same edge.
  - No match and cand==31: DONE with err=1, ctrl=0.
  - Otherwise cand<=cand+1.
- DONE:
  - rsp_valid=1; rsp_err and rsp_ctrl are stable while rsp_valid=1 && !rsp_ready.
  - On rsp_ready: go to IDLE and drop rsp_valid in the next cycle. A new request cannot be accepted in the same cycle as rsp_ready.
- Lowest matching candidate wins, so results are deterministic.
- Latency, with acceptance at edge T:
  - rsp_valid=1 in cycle T+2 for a duplicate-field request.
  - rsp_valid=1 in cycle T+3+c when the match is at candidate c.
  - rsp_valid=1 in cycle T+34 for an unroutable request.
- Routability: exactly 20 of the 24 permutations are routable. A permutation is unroutable iff out1 and out2 are both sourced from {in3,in4}, because one of out1/out2 always comes from C0.out1.
- xbar_control is unchanged by erroring requests.
- req_perm changes after acceptance are ignored.

Decomposition:
- Package crossbar_pkg holds: CTRL_W, SEL_W, NUM_PORTS=4, IDX_IN1..IDX_IN4 (0..3), state encodings IDLE/CHECK/SEARCH/DONE, CAND_MAX=31.
- One combinational sub-module, crossbar_4x4_route_model. It takes control[4:0] and outputs src_out1..src_out4 (2 bits each), mirroring the switch topology on indices instead of data.
- The bench reuses the sub-module as a golden model.

Test Plan:
- Reset then req_perm=8'b11_10_01_00 (identity) -> rsp_valid at T+3, rsp_err=0, rsp_ctrl=5'b00000, xbar_control=0.
- req_perm=8'b11_10_00_01 (out1=in2, out2=in1) -> match at cand 1: rsp_ctrl=5'b00001, rsp_valid at T+4, xbar_control=1.
- req_perm=8'b00_01_10_11 (reversal) -> unroutable: rsp_valid at T+34, rsp_err=1, rsp_ctrl=0, xbar_control keeps its previous value.
- req_perm=8'b11_10_00_00 (duplicate in1) -> rsp_valid at T+2, rsp_err=1; req_ready=0 throughout.
- Hold rsp_ready=0 for 10 cycles after a result -> rsp_valid, rsp_err and rsp_ctrl stable, req_ready=0. Then assert rst mid-SEARCH of another request -> next cycle IDLE, req_ready=1, rsp_valid=0, xbar_control=0.
- Sweep all 24 permutations -> 20 succeed; for each, feeding rsp_ctrl into the route model (and the real crossbar with distinct 4-bit data) reproduces the requested permutation. The 4 with out1,out2 sourced from {in3,in4} error.
